cpu_seq_ctrl: RTL

Parametrised successor of the tinycpu control sequencer. It decodes the 4-bit opcode held in a DW-bit instruction register and drives register-file muxes and write enables, ALU select, program-counter control and SRAM strobes. It adds configurable SRAM wait states, a HALT instruction with a resume handshake, and optional single-step debug. It sits between the sram_ctrl data bus and the datapath, replacing the fixed-timing controller.

---
 rtl/cpu_pkg.sv | 118 +++++++++++
 rtl/cpu_ws_cnt.sv | 50 +++++
 rtl/cpu_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the cpu_seq_ctrl control sequencer.
//
// Holds the opcode map, the compare-result encodings, the one-hot state
// encoding (with the bit index of every state in state_o), the register
// file mux select encodings and the SRAM strobe bundle, plus two small
// decode helpers used by the sequencer.
package cpu_pkg;

    // Opcode map, taken from inst[DW-1:DW-4].
    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_INV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_LDM  = 4'h5;
    localparam logic [3:0] OP_STM  = 4'h6;
    localparam logic [3:0] OP_HLT  = 4'h7;
    localparam logic [3:0] OP_SWAB = 4'h8;
    localparam logic [3:0] OP_SWMB = 4'h9;
    localparam logic [3:0] OP_CPPA = 4'hA;
    localparam logic [3:0] OP_CPAM = 4'hB;
    localparam logic [3:0] OP_JU   = 4'hC;
    localparam logic [3:0] OP_JE   = 4'hD;
    localparam logic [3:0] OP_JL   = 4'hE;
    localparam logic [3:0] OP_JG   = 4'hF;

    // Compare result from the datapath comparator.
    localparam logic [1:0] CMP_EQ   = 2'b00;
    localparam logic [1:0] CMP_LT   = 2'b01;
    localparam logic [1:0] CMP_GT   = 2'b10;
    localparam logic [1:0] CMP_NONE = 2'b11;

    // Bit position of each state inside the one-hot state vector.
    localparam int ST_HALT_BIT  = 6;
    localparam int ST_IDLE_BIT  = 5;
    localparam int ST_FETCH_BIT = 4;
    localparam int ST_EXEC_BIT  = 3;
    localparam int ST_MRD_BIT   = 2;
    localparam int ST_MWR_BIT   = 1;
    localparam int ST_MREC_BIT  = 0;

    typedef enum logic [6:0] {
        ST_HALT  = 7'b000_0001 << ST_HALT_BIT,
        ST_IDLE  = 7'b000_0001 << ST_IDLE_BIT,
        ST_FETCH = 7'b000_0001 << ST_FETCH_BIT,
        ST_EXEC  = 7'b000_0001 << ST_EXEC_BIT,
        ST_MRD   = 7'b000_0001 << ST_MRD_BIT,
        ST_MWR   = 7'b000_0001 << ST_MWR_BIT,
        ST_MREC  = 7'b000_0001 << ST_MREC_BIT
    } state_e;

    // Source select for register A.
    localparam logic [2:0] MUX_A_ALU = 3'd0;
    localparam logic [2:0] MUX_A_IMM = 3'd1;
    localparam logic [2:0] MUX_A_MEM = 3'd2;
    localparam logic [2:0] MUX_A_B   = 3'd3;
    localparam logic [2:0] MUX_A_P   = 3'd4;

    // Source select for register B.
    localparam logic       MUX_B_A   = 1'b0;
    localparam logic       MUX_B_M   = 1'b1;

    // Source select for register M.
    localparam logic [1:0] MUX_M_A   = 2'd0;
    localparam logic [1:0] MUX_M_B   = 2'd1;

    // SRAM strobe bundle; cen/wen/oen are active-low, den is active-high.
    typedef struct packed {
        logic den;
        logic cen;
        logic wen;
        logic oen;
    } strobe_t;

    localparam strobe_t STROBE_OFF = '{den: 1'b0, cen: 1'b1, wen: 1'b1, oen: 1'b1};

    // Strobe pattern that belongs to a state. The sequencer registers the
    // pattern of the state it is about to enter, so the pins line up with
    // the state from the first cycle of every access.
    function automatic strobe_t strobe_for(input state_e s);
        strobe_t st;
        st = STROBE_OFF;
        case (s)
            ST_FETCH, ST_MRD: begin
                st.cen = 1'b0;
                st.oen = 1'b0;
            end
            ST_MWR: begin
                st.cen = 1'b0;
                st.wen = 1'b0;
                st.den = 1'b1;
            end
            // Write strobe released but chip still selected and data still
            // driven, giving the SRAM its data hold time.
            ST_MREC: begin
                st.cen = 1'b0;
                st.den = 1'b1;
            end
            default: ;
        endcase
        return st;
    endfunction

    // Branch condition for the four jump opcodes.
    function automatic logic jump_taken(input logic [3:0] op, input logic [1:0] cmp_v);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_JU:   taken = 1'b1;
            OP_JE:   taken = (cmp_v == CMP_EQ);
            OP_JL:   taken = (cmp_v == CMP_LT);
            OP_JG:   taken = (cmp_v == CMP_GT);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/cpu_ws_cnt.sv
// cpu_ws_cnt -- SRAM wait-state counter shared by FETCH, MRD and MWR.
//
// Loadable down-counter. A load presets it to MEM_WS; while enabled it
// counts down to zero and then holds (it never wraps). `last` is high on
// the final cycle of an access, i.e. when the count has reached zero.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset (count cleared to 0)
//   load   in   preset the count to MEM_WS on the next edge
//   en     in   count down on the next edge (ignored at zero)
//   last   out  count is zero: this is the last cycle of the access
module cpu_ws_cnt #(
    parameter int MEM_WS = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic last
);

    // A zero-wait build still needs a 1-bit register.
    localparam int CW = (MEM_WS > 0) ? $clog2(MEM_WS + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_WS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Load wins over counting so a new access always starts from MEM_WS.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl -- control sequencer for the tinycpu datapath.
//
// Fetches an instruction from the SRAM controller, decodes the opcode in
// inst[DW-1:DW-4] and drives the register-file muxes/enables, ALU select,
// program-counter control and the registered SRAM strobes. Every SRAM
// access lasts MEM_WS+1 cycles. HLT parks the sequencer in HALT until a
// one-cycle resume pulse.
//
// Build option: define CPU_SEQ_CTRL_STEP_EN to enable single stepping;
// with step_mode=1 every instruction ends in HALT instead of IDLE, so each
// resume pulse retires exactly one instruction. Without the macro
// step_mode is ignored.
//
// Parameters:
//   DW      instruction/data width (>= 8)
//   MEM_WS  SRAM wait states per access (0..7)
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   dq[DW-1:0]            read data from sram_ctrl
//   cmp[1:0]              compare result: 00 EQ, 01 LT, 10 GT, 11 none
//   resume                one-cycle pulse, leaves HALT
//   step_mode             single-step enable (STEP_EN builds only)
//   mux_rA/rA_we, mux_rB/rB_we, mux_rM/rM_we   register file controls
//   den, cen, wen, oen    registered SRAM strobes (cen/wen/oen active-low)
//   alu_ctrl[1:0]         ALU function, inst[DW-3:DW-4]
//   rP_inc, rP_load       PC increment / PC load from M
//   addr_ctrl             SRAM address select: 0 = P, 1 = M
//   halted                high while in HALT
//   state_o[6:0]          one-hot state: HALT IDLE FETCH EXEC MRD MWR MREC
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int DW     = 8,
    parameter int MEM_WS = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] dq,
    input  logic [1:0]    cmp,
    input  logic          resume,
    input  logic          step_mode,
    output logic [2:0]    mux_rA,
    output logic          rA_we,
    output logic          mux_rB,
    output logic          rB_we,
    output logic [1:0]    mux_rM,
    output logic          rM_we,
    output logic          den,
    output logic          cen,
    output logic          wen,
    output logic          oen,
    output logic [1:0]    alu_ctrl,
    output logic          rP_inc,
    output logic          rP_load,
    output logic          addr_ctrl,
    output logic          halted,
    output logic [6:0]    state_o
);

    state_e        state_q;
    state_e        state_d;
    logic [DW-1:0] inst_q;
    logic [DW-1:0] inst_d;
    strobe_t       strobe_q;
    strobe_t       strobe_d;

    logic          ws_load;
    logic          ws_en;
    logic          ws_last;

    logic [3:0]    opcode;
    state_e        done_state;

    assign opcode   = inst_q[DW-1:DW-4];
    assign alu_ctrl = inst_q[DW-3:DW-4];

    // The low instruction bits carry the immediate, which the datapath
    // takes straight from its own copy; only the opcode matters here.
    logic [DW-5:0] unused_inst_low;
    assign unused_inst_low = inst_q[DW-5:0];

    // Where a finished instruction goes: back to IDLE, or to HALT when
    // single stepping so the next resume pulse releases one instruction.
`ifdef CPU_SEQ_CTRL_STEP_EN
    assign done_state = step_mode ? ST_HALT : ST_IDLE;
`else
    logic unused_step_mode;
    assign unused_step_mode = step_mode;
    assign done_state       = ST_IDLE;
`endif

    // Next-state and datapath control decode. All controls default to
    // their idle value so each state only names what it asserts.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        mux_rA    = 3'd0;
        rA_we     = 1'b0;
        mux_rB    = 1'b0;
        rB_we     = 1'b0;
        mux_rM    = 2'd0;
        rM_we     = 1'b0;
        rP_inc    = 1'b0;
        rP_load   = 1'b0;
        addr_ctrl = 1'b0;
        halted    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            // Instruction is captured and the PC bumped only on the final
            // wait cycle, when the SRAM data is guaranteed valid.
            ST_FETCH: begin
                if (ws_last) begin
                    inst_d  = dq;
                    rP_inc  = 1'b1;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = done_state;
                case (opcode)
                    OP_AND, OP_OR, OP_INV, OP_ADD: begin
                        rA_we  = 1'b1;
                        mux_rA = MUX_A_ALU;
                    end
                    OP_LDI: begin
                        rA_we  = 1'b1;
                        mux_rA = MUX_A_IMM;
                    end
                    OP_LDM: begin
                        state_d = ST_MRD;
                    end
                    OP_STM: begin
                        state_d = ST_MWR;
                    end
                    OP_HLT: begin
                        state_d = ST_HALT;
                    end
                    OP_SWAB: begin
                        rA_we  = 1'b1;
                        mux_rA = MUX_A_B;
                        rB_we  = 1'b1;
                        mux_rB = MUX_B_A;
                    end
                    OP_SWMB: begin
                        rM_we  = 1'b1;
                        mux_rM = MUX_M_B;
                        rB_we  = 1'b1;
                        mux_rB = MUX_B_M;
                    end
                    OP_CPPA: begin
                        rA_we  = 1'b1;
                        mux_rA = MUX_A_P;
                    end
                    OP_CPAM: begin
                        rM_we  = 1'b1;
                        mux_rM = MUX_M_A;
                    end
                    OP_JU, OP_JE, OP_JL, OP_JG: begin
                        rP_load = jump_taken(opcode, cmp);
                    end
                    default: ;
                endcase
            end

            ST_MRD: begin
                addr_ctrl = 1'b1;
                if (ws_last) begin
                    rA_we   = 1'b1;
                    mux_rA  = MUX_A_MEM;
                    state_d = done_state;
                end
            end

            ST_MWR: begin
                addr_ctrl = 1'b1;
                if (ws_last) begin
                    state_d = ST_MREC;
                end
            end

            ST_MREC: begin
                addr_ctrl = 1'b1;
                state_d   = done_state;
            end

            ST_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The wait counter restarts on entry to any SRAM access state and
    // counts down only while such a state is active.
    always_comb begin
        ws_load = 1'b0;
        ws_en   = 1'b0;
        if ((state_d != state_q) &&
            ((state_d == ST_FETCH) || (state_d == ST_MRD) || (state_d == ST_MWR))) begin
            ws_load = 1'b1;
        end
        if ((state_q == ST_FETCH) || (state_q == ST_MRD) || (state_q == ST_MWR)) begin
            ws_en = 1'b1;
        end
    end

    // Strobes are registered from the upcoming state, so they are glitch
    // free and track state_q cycle for cycle.
    always_comb begin
        strobe_d = strobe_for(state_d);
    end

    // Reset drops every strobe immediately, abandoning any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            inst_q   <= '0;
            strobe_q <= STROBE_OFF;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            strobe_q <= strobe_d;
        end
    end

    cpu_ws_cnt #(
        .MEM_WS (MEM_WS)
    ) u_ws_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ws_load),
        .en    (ws_en),
        .last  (ws_last)
    );

    assign den     = strobe_q.den;
    assign cen     = strobe_q.cen;
    assign wen     = strobe_q.wen;
    assign oen     = strobe_q.oen;
    assign state_o = state_q;

endmodule
